// File: rtl/enigma_pkg.sv
// Shared types and constants for the cipher output path: letter width,
// ASCII mapping constants and the UART transmitter state encoding.
package enigma_pkg;

    localparam int          LETTER_W      = 6;
    localparam int          NUM_LETTERS   = 26;
    localparam logic [7:0]  ASCII_A       = 8'h41;
    localparam logic [7:0]  ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Indices outside A..Z print as '?' so a corrupted index is visible on the terminal.
    function automatic logic [7:0] letter_to_ascii(input logic [LETTER_W-1:0] idx);
        if (idx < LETTER_W'(NUM_LETTERS))
            return ASCII_A + 8'(idx);
        else
            return ASCII_UNKNOWN;
    endfunction

endpackage

// File: rtl/uart_letter_tx_if.sv
// Letter handshake between the mapping stage (master) and the UART output stage (slave).
interface uart_letter_tx_if;
    import enigma_pkg::*;

    logic [LETTER_W-1:0] letter_in;
    logic                letter_valid;
    logic                letter_ready;

    modport master (output letter_in, output letter_valid, input  letter_ready);
    modport slave  (input  letter_in, input  letter_valid, output letter_ready);

endinterface

// File: rtl/uart_letter_tx_fifo.sv
// Small synchronous byte FIFO with occupancy count; head is readable without a pop
// so the transmitter can load its shift register on the same edge it pops.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    // Pointers are PTR_W bits wide, so wrap modulo DEPTH happens naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_letter_tx.sv
// Cipher output stage: maps letter indices to ASCII, buffers them and sends each
// byte as an 8N1 UART frame, LSB first, with back-to-back frames when data waits.
module uart_letter_tx
    import enigma_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_letter_tx_if.slave               lif,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             push;
    logic             pop;
    logic             overflow_reg;

    tx_state_t        state_reg,  state_next;
    logic [BAUD_W-1:0] baud_reg,  baud_next;
    logic [2:0]       bit_reg,    bit_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             txd_reg,    txd_next;
    logic             baud_last;

    assign lif.letter_ready = !fifo_full;
    assign push             = lif.letter_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (letter_to_ascii(lif.letter_in)),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow_reg <= 1'b0;
        else if (lif.letter_valid && fifo_full)
            overflow_reg <= 1'b1;
    end
    assign overflow = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
        end
    end

    assign baud_last = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    shift_next = fifo_dout;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next  = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7)
                        state_next = STOP;
                end else begin
                    baud_next  = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (pop) begin
                        shift_next = fifo_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Line level is decided from the upcoming state so txd comes straight off a flop.
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        tx_busy = (state_reg != IDLE);
        if (!fifo_empty) begin
            if (state_reg == IDLE)
                pop = 1'b1;
            else if (state_reg == STOP && baud_last)
                pop = 1'b1;
        end
    end

    assign txd = txd_reg;

endmodule

// File: tb/tb_uart_letter_tx.sv
// Directed bench for uart_letter_tx at 10 clocks per bit: frame contents and timing,
// back-to-back frames, '?' mapping, full/overflow behaviour and mid-frame reset.
module tb_uart_letter_tx;
    import enigma_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txd;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       overflow;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    uart_letter_tx_if lif ();

    uart_letter_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lif        (lif),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a start bit, samples every bit in its middle and compares the byte.
    task automatic recv_byte(input string tag, input logic [7:0] exp, output int start_cyc);
        int n = 0;
        logic [7:0] b;
        while (txd !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_start_edge"}, 32'(txd), 32'd0);
        start_cyc = cyc;
        repeat (5) step();
        check({tag, "_start_mid"}, 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) step();
            b[i] = txd;
        end
        repeat (10) step();
        check({tag, "_stop"}, 32'(txd), 32'd1);
        check({tag, "_byte"}, 32'(b), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lif.letter_valid = 1'b0;
        lif.letter_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push_one(input logic [5:0] l);
        lif.letter_in = l;
        lif.letter_valid = 1'b1;
        step();
        lif.letter_valid = 1'b0;
    endtask

    initial begin
        int s1, s2;
        int n;
        logic seen;

        // Reset state
        do_reset();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready", 32'(lif.letter_ready), 32'd1);

        // Single 'A' frame, 100 busy cycles
        push_one(6'd0);
        check("a_count_after_push", 32'(fifo_count), 32'd1);
        recv_byte("a", 8'h41, s1);
        repeat (4) step();
        check("a_busy_c99", 32'(tx_busy), 32'd1);
        step();
        check("a_busy_c100", 32'(tx_busy), 32'd0);
        check("a_txd_idle", 32'(txd), 32'd1);

        // 'Z' then 'H' back-to-back
        lif.letter_in = 6'd25; lif.letter_valid = 1'b1; step();
        lif.letter_in = 6'd7;  step();
        lif.letter_valid = 1'b0;
        recv_byte("z", 8'h5A, s1);
        recv_byte("h", 8'h48, s2);
        check("zh_gap", 32'(s2 - s1), 32'd100);
        repeat (4) step();
        check("zh_busy_c199", 32'(tx_busy), 32'd1);
        step();
        check("zh_busy_c200", 32'(tx_busy), 32'd0);

        // Out-of-range indices map to '?'
        lif.letter_in = 6'd30; lif.letter_valid = 1'b1; step();
        lif.letter_in = 6'd63; step();
        lif.letter_valid = 1'b0;
        recv_byte("idx30", 8'h3F, s1);
        recv_byte("idx63", 8'h3F, s1);
        repeat (10) step();

        // Fill to capacity, overflow, refill after the first pop
        do_reset();
        fork
            begin
                int st;
                for (int i = 0; i < 18; i++)
                    recv_byte($sformatf("fill%0d", i), 8'h41 + 8'(i), st);
            end
            begin
                for (int i = 0; i < 18; i++) begin
                    lif.letter_in = 6'(i);
                    lif.letter_valid = 1'b1;
                    step();
                    if (i == 15) check("fill_ovf_before", 32'(overflow), 32'd0);
                    if (i == 16) begin
                        check("fill_ready_full", 32'(lif.letter_ready), 32'd0);
                        check("fill_count_full", 32'(fifo_count), 32'd16);
                        check("fill_ovf_at_full", 32'(overflow), 32'd0);
                    end
                end
                check("fill_ovf_set", 32'(overflow), 32'd1);
                check("fill_count_refused", 32'(fifo_count), 32'd16);
                n = 0;
                while (lif.letter_ready !== 1'b1 && n < 300) begin
                    step();
                    n++;
                end
                check("pop_ready_back", 32'(lif.letter_ready), 32'd1);
                check("pop_count_15", 32'(fifo_count), 32'd15);
                step();
                lif.letter_valid = 1'b0;
                check("pop_count_16", 32'(fifo_count), 32'd16);
                check("pop_ready_low", 32'(lif.letter_ready), 32'd0);
            end
        join
        check("fill_ovf_sticky", 32'(overflow), 32'd1);
        repeat (10) step();

        // Reset mid-DATA with 5 bytes buffered
        do_reset();
        for (int i = 0; i < 6; i++) begin
            lif.letter_in = 6'(i + 2);
            lif.letter_valid = 1'b1;
            step();
        end
        lif.letter_valid = 1'b0;
        check("mid_count_5", 32'(fifo_count), 32'd5);
        repeat (25) step();
        check("mid_busy", 32'(tx_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (150) begin
            step();
            if (txd !== 1'b1 || tx_busy !== 1'b0) seen = 1'b1;
        end
        check("mid_quiet_after_rst", 32'(seen), 32'd0);
        push_one(6'd3);
        recv_byte("after_rst", 8'h44, s1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
